// File: rtl/cache_pkg.sv
// ---------------------------------------------------------------------------
// cache_pkg
// Shared helpers for the cache controller slice.
//   - Address field widths (offset / set / tag) derived from the cache
//     geometry parameters.
//   - Tree pseudo-LRU helpers operating on a maximum-size node vector so
//     one function body serves every power-of-two associativity up to
//     2**MAX_LEVELS ways. Callers zero-extend their tree bits in and cast
//     the results back to their own widths.
//   - Replacement FSM state encoding.
// Tree layout: node 0 is the root, children of node i are 2i+1 and 2i+2,
// leaves map to ways 0..N-1 left to right. A node bit of 0 points the
// victim search into the left subtree, 1 into the right subtree.
// ---------------------------------------------------------------------------
package cache_pkg;

   localparam int MAX_LEVELS = 5;   // up to 32 ways
   localparam int MAX_WAY_W  = 5;
   localparam int NODE_VEC   = 64;  // covers every node and leaf index
   localparam int NODE_IDX_W = 6;

   typedef enum logic [0:0] {
      PLRU_IDLE  = 1'b0,
      PLRU_SWEEP = 1'b1
   } plru_state_e;

   function automatic int offset_width(input int block_size);
      return $clog2(block_size / 4);
   endfunction

   function automatic int set_width(input int num_sets);
      return $clog2(num_sets);
   endfunction

   function automatic int tag_width(input int addr_size, input int num_sets,
                                    input int block_size);
      return addr_size - offset_width(block_size) - set_width(num_sets);
   endfunction

   // Follow the node bits from the root down to a leaf, return the way.
   function automatic logic [MAX_WAY_W-1:0] plru_victim(
      input logic [NODE_VEC-1:0] bits,
      input int                  levels
   );
      logic [NODE_IDX_W-1:0] node;
      logic [NODE_IDX_W-1:0] base;
      node = '0;
      for (int l = 0; l < MAX_LEVELS; l++) begin
         if (l < levels) begin
            node = {node[NODE_IDX_W-2:0], 1'b0} + NODE_IDX_W'(1)
                 + NODE_IDX_W'(bits[node]);
         end
      end
      // Leaves of a tree with 'levels' levels start at index 2**levels-1.
      base = NODE_IDX_W'((1 << levels) - 1);
      return MAX_WAY_W'(node - base);
   endfunction

   // Point every node on the root-to-way path away from 'way'.
   function automatic logic [NODE_VEC-1:0] plru_touch(
      input logic [NODE_VEC-1:0]  bits,
      input logic [MAX_WAY_W-1:0] way,
      input int                   levels
   );
      logic [NODE_VEC-1:0]   nb;
      logic [NODE_IDX_W-1:0] node;
      logic [MAX_WAY_W-1:0]  path;
      logic                  dir;
      nb   = bits;
      node = '0;
      // Left-align the way number so its MSB picks the root branch.
      path = way << (MAX_LEVELS - levels);
      for (int l = 0; l < MAX_LEVELS; l++) begin
         if (l < levels) begin
            dir      = path[MAX_WAY_W-1];
            nb[node] = ~dir;
            node     = {node[NODE_IDX_W-2:0], 1'b0} + NODE_IDX_W'(1)
                     + NODE_IDX_W'(dir);
            path     = path << 1;
         end
      end
      return nb;
   endfunction

endpackage

// File: rtl/plru_tree.sv
// ---------------------------------------------------------------------------
// plru_tree
// Combinational victim selection and state update for a single set.
// Ports:
//   tree_bits  in  NUM_WAYS-1       stored tree bits of the set
//   valid_mask in  NUM_WAYS         valid bits of the set's ways
//   hit        in  1                touch hit_way
//   hit_way    in  $clog2(NUM_WAYS) way that hit
//   replace    in  1                touch the victim (wins over hit)
//   victim     out $clog2(NUM_WAYS) lowest invalid way, else tree choice
//   next_bits  out NUM_WAYS-1       tree bits after the touch
//   touch      out 1                a touch is requested this cycle
// ---------------------------------------------------------------------------
module plru_tree
   import cache_pkg::*;
#(
   parameter int NUM_WAYS = 4
) (
   input  logic [NUM_WAYS-2:0]         tree_bits,
   input  logic [NUM_WAYS-1:0]         valid_mask,
   input  logic                        hit,
   input  logic [$clog2(NUM_WAYS)-1:0] hit_way,
   input  logic                        replace,
   output logic [$clog2(NUM_WAYS)-1:0] victim,
   output logic [NUM_WAYS-2:0]         next_bits,
   output logic                        touch
);

   localparam int WAY_W  = $clog2(NUM_WAYS);
   localparam int NODES  = NUM_WAYS - 1;
   localparam int LEVELS = WAY_W;

   logic             any_invalid;
   logic [WAY_W-1:0] first_invalid;
   logic [WAY_W-1:0] tree_way;
   logic [WAY_W-1:0] touch_way;

   // Scan downwards so the last assignment is the lowest invalid way.
   always_comb begin
      any_invalid   = 1'b0;
      first_invalid = '0;
      for (int i = NUM_WAYS - 1; i >= 0; i--) begin
         if (!valid_mask[i]) begin
            any_invalid   = 1'b1;
            first_invalid = WAY_W'(i);
         end
      end
   end

   assign tree_way = WAY_W'(plru_victim(NODE_VEC'(tree_bits), LEVELS));
   assign victim   = any_invalid ? first_invalid : tree_way;

   // A fill lands on the reported victim, so replace touches that way even
   // when it was chosen because it was invalid.
   always_comb begin
      touch     = replace || hit;
      touch_way = replace ? victim : hit_way;
      next_bits = NODES'(plru_touch(NODE_VEC'(tree_bits),
                                    MAX_WAY_W'(touch_way), LEVELS));
   end

endmodule

// File: rtl/n_way_plru_cru.sv
// ---------------------------------------------------------------------------
// n_way_plru_cru
// Tree pseudo-LRU replacement unit for a set-associative cache. Holds one
// tree per set, reports the way to fill for the addressed set and updates
// the tree on hits and fills. A flush clears every tree, one set per cycle.
// Ports:
//   clk        in  1                clock
//   rst        in  1                synchronous active-low reset
//   addr       in  ADDR_SIZE        access address (offset | set | tag)
//   valid_mask in  NUM_WAYS         valid bits of the addressed set
//   hit        in  1                touch hit_way in the addressed set
//   hit_way    in  $clog2(NUM_WAYS) way that hit
//   replace    in  1                fill committed to 'preferred'; touch it
//   flush      in  1                clear all replacement state
//   preferred  out $clog2(NUM_WAYS) way to fill for the addressed set
//   busy       out 1                flush sweep in progress
//
// Request handshake: hit, replace and flush are single-cycle requests that
// are taken at the rising edge ending any cycle in which busy=0, and are
// dropped without effect in any cycle in which busy=1. replace has priority
// over hit. There is no back-pressure beyond busy.
// ---------------------------------------------------------------------------
module n_way_plru_cru
   import cache_pkg::*;
#(
   parameter int ADDR_SIZE  = 32,
   parameter int NUM_SETS   = 16,
   parameter int NUM_WAYS   = 4,
   parameter int BLOCK_SIZE = 32
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [ADDR_SIZE-1:0]        addr,
   input  logic [NUM_WAYS-1:0]         valid_mask,
   input  logic                        hit,
   input  logic [$clog2(NUM_WAYS)-1:0] hit_way,
   input  logic                        replace,
   input  logic                        flush,
   output logic [$clog2(NUM_WAYS)-1:0] preferred,
   output logic                        busy
);

   localparam int OFF_W = offset_width(BLOCK_SIZE);
   localparam int SET_W = set_width(NUM_SETS);
   localparam int NODES = NUM_WAYS - 1;

   // FSM state and sweep index kept together so a checker can bind to one
   // signal for the whole controller state.
   typedef struct packed {
      plru_state_e      state;
      logic [SET_W-1:0] sweep_cnt;
   } fsm_dbg_t;

   fsm_dbg_t         fsm_q;
   fsm_dbg_t         fsm_d;
   logic             clr_en;

   logic [NODES-1:0] tree_q [NUM_SETS];
   logic [SET_W-1:0] set_idx;
   logic [NODES-1:0] cur_bits;
   logic [NODES-1:0] next_bits;
   logic             touch;
   logic             wr_en;

   assign set_idx  = addr[OFF_W +: SET_W];
   assign cur_bits = tree_q[set_idx];

   plru_tree #(
      .NUM_WAYS (NUM_WAYS)
   ) u_tree (
      .tree_bits  (cur_bits),
      .valid_mask (valid_mask),
      .hit        (hit),
      .hit_way    (hit_way),
      .replace    (replace),
      .victim     (preferred),
      .next_bits  (next_bits),
      .touch      (touch)
   );

   assign wr_en = touch && !busy;

   always_comb begin
      fsm_d  = fsm_q;
      clr_en = 1'b0;
      busy   = 1'b0;
      case (fsm_q.state)
         PLRU_IDLE: begin
            if (flush) begin
               fsm_d.state     = PLRU_SWEEP;
               fsm_d.sweep_cnt = '0;
            end
         end
         PLRU_SWEEP: begin
            busy            = 1'b1;
            clr_en          = 1'b1;
            fsm_d.sweep_cnt = fsm_q.sweep_cnt + 1'b1;
            if (fsm_q.sweep_cnt == SET_W'(NUM_SETS - 1)) begin
               fsm_d.state = PLRU_IDLE;
            end
         end
         default: begin
            fsm_d.state = PLRU_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         fsm_q.state     <= PLRU_IDLE;
         fsm_q.sweep_cnt <= '0;
         for (int s = 0; s < NUM_SETS; s++) begin
            tree_q[s] <= '0;
         end
      end else begin
         fsm_q <= fsm_d;
         // Sweep and access updates never coincide: wr_en is masked by busy.
         if (clr_en) begin
            tree_q[fsm_q.sweep_cnt] <= '0;
         end else if (wr_en) begin
            tree_q[set_idx] <= next_bits;
         end
      end
   end

endmodule

// File: doc/n_way_plru_cru.md
# n_way_plru_cru

Parametrised cache replacement unit for set-associative caches of any power-of-two associativity. It keeps one tree pseudo-LRU state per set and reports the way to fill for the addressed set, preferring an invalid way over the tree choice. It updates that state on hits and fills, and provides a multi-cycle flush sweep. It sits beside the tag/data arrays of the cache controller and replaces the fixed two-way toggle unit.

## Interface
Parameters:
- ADDR_SIZE, 32, address width.
- NUM_SETS, 16, number of sets; power of two, ≥2.
- NUM_WAYS, 4, associativity; power of two, ≥2.
- BLOCK_SIZE, 32, block size in the cache's units. Byte-offset field width = $clog2(BLOCK_SIZE/4).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-low.
- addr  in  ADDR_SIZE  access address. Field layout from LSB: byte offset, set, tag.
- valid_mask  in  NUM_WAYS  valid bits of the addressed set, from the tag array.
- hit  in  1  access hit; touch hit_way in the addressed set.
- hit_way  in  $clog2(NUM_WAYS)  way that hit.
- replace  in  1  fill committed to the `preferred` way; touch that way.
- flush  in  1  request to clear all PLRU state.
- preferred  out  $clog2(NUM_WAYS)  way to fill for the addressed set.
- busy  out  1  flush sweep in progress.

## Operation
- State per set: NUM_WAYS-1 tree bits. Node 0 is the root; the children of node i are 2i+1 and 2i+2. Leaves map to ways 0..NUM_WAYS-1, left to right. Bit value 0 means the victim lies in the left subtree; 1 means the right subtree.
- Victim selection is combinational:
  - If any valid_mask bit is 0, `preferred` = lowest-index invalid way.
  - Otherwise `preferred` = leaf reached by following the tree bits from the root.
- Touch of way w: every node on the path to w is set to point away from w. Nodes off the path are unchanged.
- hit (not busy): touch hit_way.
- replace (not busy): touch the current `preferred` value, including the invalid-way case.
- hit and replace in the same cycle: replace wins and hit is ignored. The bench flags this as a protocol warning.
- FSM states:
  - IDLE: flush=1 → SWEEP with sweep counter = 0.
  - SWEEP: each cycle clears the set at the counter index and increments the counter. After set NUM_SETS-1 is cleared → IDLE.
- busy = (state == SWEEP).
- While busy:
  - hit, replace and flush are ignored.
  - `preferred` still reflects the stored state and valid_mask, which may be partially cleared.
- Reset (rst=0 at an edge):
  - all tree bits cleared; FSM → IDLE; counter → 0.
  - overrides everything, including a flush in progress.
- Reset values: busy=0. `preferred` = lowest invalid way, or way 0 if valid_mask is all ones.

## Timing
- `preferred` has zero latency from addr and valid_mask. It uses state as of the current cycle.
- Touches take effect at the next rising edge; an access in the next cycle sees the updated state.
- Flush accepted in cycle T (busy=0):
  - busy=1 in cycles T+1 .. T+NUM_SETS.
  - set k is cleared at the edge ending cycle T+1+k.
  - busy=0 from cycle T+NUM_SETS+1. New requests are accepted in that cycle.
- Flush held high continuously: a new sweep starts in the first cycle busy=0.

## Structure
- Shared package `cache_pkg` holds:
  - address-field width helpers: offset, set and tag widths as functions of the parameters;
  - `plru_victim` function (tree bits → way);
  - `plru_touch` function (tree bits, way → tree bits).
- Sub-module `plru_tree` is combinational. For one set it computes victim and next state, selecting the invalid way when one exists. It is instantiated once, on the addressed set.
- The top level holds the state array, the FSM and the sweep counter.

## Test plan
All scenarios use NUM_WAYS=4 and NUM_SETS=16; addr 0x18 → set 3.
- Reset, then valid_mask=4'hF, addr 0x18 → preferred=0, busy=0.
- Four replace pulses on set 3 with valid_mask=4'hF → preferred sequence 0,2,1,3, then back to 0.
- Reset, hit way 0 on set 3 → next cycle preferred=2; sets 0–2 and 4–15 still give 0.
- valid_mask=4'b1011 after tree has been trained toward way 1 → preferred=2. replace → the following cycle with full mask shows way 2 touched.
- Train several sets, flush → busy high exactly 16 cycles; hits during busy have no effect; afterwards every set gives preferred=0.
- Flush, then rst=0 at sweep cycle 5 → next cycle busy=0 and all sets cleared.
